// File: rtl/onbellek_paket.sv
// Shared definitions for the instruction cache: FSM encoding, default geometry
// and address-field extraction helpers.
package onbellek_paket;

    typedef enum logic [1:0] {
        BOSTA   = 2'd0,
        DOLDUR  = 2'd1,
        YANITLA = 2'd2
    } durum_t;

    localparam int VARSAYILAN_SATIR_SAYISI   = 64;
    localparam int VARSAYILAN_SATIR_KELIME   = 4;
    localparam int VARSAYILAN_ADRES_GENISLIK = 32;

    localparam int OFSET_GENISLIK  = $clog2(VARSAYILAN_SATIR_KELIME);
    localparam int INDEKS_GENISLIK = $clog2(VARSAYILAN_SATIR_SAYISI);
    localparam int ETIKET_GENISLIK = VARSAYILAN_ADRES_GENISLIK - 2 - OFSET_GENISLIK - INDEKS_GENISLIK;

    // Helpers return full-width fields; callers size-cast to their own widths.
    function automatic logic [31:0] ofset_al(input logic [31:0] ps, input int ofs_w);
        return (ps >> 2) & ((32'd1 << ofs_w) - 32'd1);
    endfunction

    function automatic logic [31:0] indeks_al(input logic [31:0] ps, input int ofs_w, input int idx_w);
        return (ps >> (2 + ofs_w)) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] etiket_al(input logic [31:0] ps, input int ofs_w, input int idx_w);
        return ps >> (2 + ofs_w + idx_w);
    endfunction

endpackage

// File: rtl/onbellek_veri_dizisi.sv
// Tag and data storage for the instruction cache: one refill write port and one
// synchronous read port. Valid bits live in the parent.
module onbellek_veri_dizisi #(
    parameter int SATIR_SAYISI = 64,
    parameter int SATIR_KELIME = 4,
    parameter int ETIKET_W     = 22
) (
    input  logic                            clk,
    input  logic                            veri_yaz,
    input  logic                            etiket_yaz,
    input  logic [$clog2(SATIR_SAYISI)-1:0] yaz_indeks,
    input  logic [$clog2(SATIR_KELIME)-1:0] yaz_ofset,
    input  logic [31:0]                     yaz_veri,
    input  logic [ETIKET_W-1:0]             yaz_etiket,
    input  logic [$clog2(SATIR_SAYISI)-1:0] oku_indeks,
    input  logic [$clog2(SATIR_KELIME)-1:0] oku_ofset,
    output logic [ETIKET_W-1:0]             oku_etiket,
    output logic [31:0]                     oku_veri
);

    logic [ETIKET_W-1:0] etiket_dizi [SATIR_SAYISI];
    logic [31:0]         veri_dizi   [SATIR_SAYISI*SATIR_KELIME];

    always_ff @(posedge clk) begin
        if (veri_yaz) begin
            veri_dizi[{yaz_indeks, yaz_ofset}] <= yaz_veri;
        end
        if (etiket_yaz) begin
            etiket_dizi[yaz_indeks] <= yaz_etiket;
        end
        oku_etiket <= etiket_dizi[oku_indeks];
        oku_veri   <= veri_dizi[{oku_indeks, oku_ofset}];
    end

endmodule

// File: rtl/buyruk_onbellegi.sv
// Direct-mapped read-only instruction cache with whole-line refill and fence.i flush.
// Optional hit/miss counters are built when ONBELLEK_SAYAC_EN is defined.
module buyruk_onbellegi
    import onbellek_paket::*;
#(
    parameter int SATIR_SAYISI   = VARSAYILAN_SATIR_SAYISI,
    parameter int SATIR_KELIME   = VARSAYILAN_SATIR_KELIME,
    parameter int ADRES_GENISLIK = VARSAYILAN_ADRES_GENISLIK
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      bellek_istek_i,
    input  logic [ADRES_GENISLIK-1:0] bellek_ps_i,
    output logic                      bellek_gecerli_o,
    output logic [31:0]               bellek_deger_o,
    input  logic                      temizle_i,
    output logic                      ana_bellek_istek_o,
    output logic [ADRES_GENISLIK-1:0] ana_bellek_adres_o,
    input  logic                      ana_bellek_gecerli_i,
    input  logic [31:0]               ana_bellek_veri_i
`ifdef ONBELLEK_SAYAC_EN
    ,
    output logic [31:0]               isabet_sayisi_o,
    output logic [31:0]               iska_sayisi_o
`endif
);

    localparam int OW = $clog2(SATIR_KELIME);
    localparam int IW = $clog2(SATIR_SAYISI);
    localparam int TW = ADRES_GENISLIK - 2 - OW - IW;

    durum_t durum, durum_sonraki;

    logic                      arama;
    logic [ADRES_GENISLIK-1:0] arama_ps;
    logic                      bekleyen_dolu;
    logic [ADRES_GENISLIK-1:0] bekleyen_ps;
    logic [OW-1:0]             sayac;
    logic                      zehir;
    logic [SATIR_SAYISI-1:0]   gecerli_bitler;
    logic [31:0]               yanit_kelime;

    logic                      arama_baslat, bekleyen_yaz, bekleyen_sil, doldur_gir;
    logic [ADRES_GENISLIK-1:0] arama_adres;
    logic [TW-1:0]             arama_etiket, oku_etiket;
    logic [IW-1:0]             arama_indeks, oku_indeks;
    logic [OW-1:0]             arama_ofset, oku_ofset;
    logic [31:0]               oku_veri;
    logic                      vurus, son_vurus, arama_isabet;

    assign arama_etiket = TW'(etiket_al(32'(arama_ps), OW, IW));
    assign arama_indeks = IW'(indeks_al(32'(arama_ps), OW, IW));
    assign arama_ofset  = OW'(ofset_al(32'(arama_ps), OW));
    assign oku_indeks   = IW'(indeks_al(32'(arama_adres), OW, IW));
    assign oku_ofset    = OW'(ofset_al(32'(arama_adres), OW));

    assign vurus        = (durum == DOLDUR) && ana_bellek_gecerli_i;
    assign son_vurus    = vurus && (sayac == OW'(SATIR_KELIME - 1));
    // Arrays were read in the request cycle; tag compare happens one cycle later.
    assign arama_isabet = arama && gecerli_bitler[arama_indeks] && (oku_etiket == arama_etiket);

    assign ana_bellek_istek_o = (durum == DOLDUR);
    assign ana_bellek_adres_o = (durum == DOLDUR) ? {arama_ps[ADRES_GENISLIK-1:2+OW], sayac, 2'b00} : '0;

    onbellek_veri_dizisi #(
        .SATIR_SAYISI (SATIR_SAYISI),
        .SATIR_KELIME (SATIR_KELIME),
        .ETIKET_W     (TW)
    ) u_dizi (
        .clk        (clk_i),
        .veri_yaz   (vurus),
        .etiket_yaz (son_vurus),
        .yaz_indeks (arama_indeks),
        .yaz_ofset  (sayac),
        .yaz_veri   (ana_bellek_veri_i),
        .yaz_etiket (arama_etiket),
        .oku_indeks (oku_indeks),
        .oku_ofset  (oku_ofset),
        .oku_etiket (oku_etiket),
        .oku_veri   (oku_veri)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum <= BOSTA;
        end else begin
            durum <= durum_sonraki;
        end
    end

    always_comb begin
        durum_sonraki    = durum;
        arama_baslat     = 1'b0;
        arama_adres      = bellek_ps_i;
        bekleyen_yaz     = 1'b0;
        bekleyen_sil     = 1'b0;
        doldur_gir       = 1'b0;
        bellek_gecerli_o = 1'b0;
        bellek_deger_o   = '0;
        unique case (durum)
            BOSTA: begin
                if (arama && !arama_isabet) begin
                    durum_sonraki = DOLDUR;
                    doldur_gir    = 1'b1;
                    bekleyen_yaz  = bellek_istek_i;
                end else begin
                    bellek_gecerli_o = arama_isabet;
                    bellek_deger_o   = arama_isabet ? oku_veri : '0;
                    arama_baslat     = bellek_istek_i;
                end
            end
            DOLDUR: begin
                bekleyen_yaz = bellek_istek_i;
                if (son_vurus) begin
                    durum_sonraki = YANITLA;
                end
            end
            YANITLA: begin
                durum_sonraki = BOSTA;
                // A newer request (held or arriving now) replaces the stale miss response.
                if (bekleyen_dolu || bellek_istek_i) begin
                    arama_baslat = 1'b1;
                    bekleyen_sil = 1'b1;
                    if (!bellek_istek_i) begin
                        arama_adres = bekleyen_ps;
                    end
                end else begin
                    bellek_gecerli_o = 1'b1;
                    bellek_deger_o   = yanit_kelime;
                end
            end
            default: durum_sonraki = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            arama          <= 1'b0;
            bekleyen_dolu  <= 1'b0;
            sayac          <= '0;
            zehir          <= 1'b0;
            gecerli_bitler <= '0;
        end else begin
            arama <= arama_baslat;
            if (bekleyen_sil) begin
                bekleyen_dolu <= 1'b0;
            end else if (bekleyen_yaz) begin
                bekleyen_dolu <= 1'b1;
            end
            if (vurus) begin
                sayac <= son_vurus ? '0 : sayac + 1'b1;
            end
            if (doldur_gir) begin
                zehir <= 1'b0;
            end else if ((durum == DOLDUR) && temizle_i) begin
                zehir <= 1'b1;
            end
            // A flush in the last-beat cycle also keeps the line invalid.
            if (temizle_i) begin
                gecerli_bitler <= '0;
            end else if (son_vurus && !zehir) begin
                gecerli_bitler[arama_indeks] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (arama_baslat) begin
            arama_ps <= arama_adres;
        end
        if (bekleyen_yaz) begin
            bekleyen_ps <= bellek_ps_i;
        end
        if (vurus && (sayac == arama_ofset)) begin
            yanit_kelime <= ana_bellek_veri_i;
        end
    end

`ifdef ONBELLEK_SAYAC_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            isabet_sayisi_o <= '0;
            iska_sayisi_o   <= '0;
        end else begin
            if (arama_isabet && (isabet_sayisi_o != '1)) begin
                isabet_sayisi_o <= isabet_sayisi_o + 32'd1;
            end
            if (doldur_gir && (iska_sayisi_o != '1)) begin
                iska_sayisi_o <= iska_sayisi_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_buyruk_onbellegi.sv
// Directed bench for buyruk_onbellegi: memory responder with configurable wait,
// response monitor, and hand-computed expectations for each scenario.
module tb_buyruk_onbellegi;

    logic        clk = 1'b0;
    logic        rst, istek, temizle, ana_gecerli;
    logic [31:0] ps, ana_veri;
    logic        gecerli, ana_istek;
    logic [31:0] deger, ana_adres;
`ifdef ONBELLEK_SAYAC_EN
    logic [31:0] isabet_sayisi, iska_sayisi;
`endif

    int          n_assert = 0;
    int          n_fail   = 0;
    int          mem_bekleme = 2;
    int          vurus = 0;
    int          v0, g;
    logic [31:0] adr_q[$];
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    buyruk_onbellegi dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .bellek_istek_i       (istek),
        .bellek_ps_i          (ps),
        .bellek_gecerli_o     (gecerli),
        .bellek_deger_o       (deger),
        .temizle_i            (temizle),
        .ana_bellek_istek_o   (ana_istek),
        .ana_bellek_adres_o   (ana_adres),
        .ana_bellek_gecerli_i (ana_gecerli),
        .ana_bellek_veri_i    (ana_veri)
`ifdef ONBELLEK_SAYAC_EN
        ,
        .isabet_sayisi_o      (isabet_sayisi),
        .iska_sayisi_o        (iska_sayisi)
`endif
    );

    function automatic logic [31:0] mem_kelime(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        n_assert++;
        assert (gozlenen === beklenen) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic adim(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic iste(input logic [31:0] a);
        istek = 1'b1;
        ps    = a;
        adim();
        istek = 1'b0;
    endtask

    task automatic yanit_bekle(input string etiket, input logic [31:0] beklenen, output int gecikme);
        exp_q.push_back(beklenen);
        gecikme = 0;
        while (got_q.size() == 0 && gecikme < 300) begin
            adim();
            gecikme++;
        end
        if (got_q.size() == 0) begin
            kontrol({etiket, "_yanit_yok"}, 32'(got_q.size()), 32'd1);
            void'(exp_q.pop_front());
        end else begin
            kontrol(etiket, got_q.pop_front(), exp_q.pop_front());
        end
    endtask

    task automatic vurus_bekle(input string etiket, input int hedef);
        int t = 0;
        while (vurus < hedef && t < 200) begin
            adim();
            t++;
        end
        if (vurus < hedef) kontrol(etiket, 32'(vurus), 32'(hedef));
    endtask

    // Response monitor: one entry per valid pulse.
    always @(negedge clk) begin
        if (gecerli) got_q.push_back(deger);
    end

    // Main-memory model: mem_bekleme wait cycles per beat, one beat per handshake.
    initial begin
        int bekle;
        ana_gecerli = 1'b0;
        ana_veri    = '0;
        bekle       = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ana_gecerli) begin
                ana_gecerli = 1'b0;
                vurus++;
                bekle = 0;
            end else if (ana_istek && !rst) begin
                if (bekle >= mem_bekleme) begin
                    ana_gecerli = 1'b1;
                    ana_veri    = mem_kelime(ana_adres);
                    adr_q.push_back(ana_adres);
                end else begin
                    bekle++;
                end
            end else begin
                bekle = 0;
            end
        end
    end

    initial begin
        rst     = 1'b1;
        istek   = 1'b0;
        temizle = 1'b0;
        ps      = '0;
        adim(3);
        kontrol("reset_gecerli", {31'b0, gecerli}, 32'd0);
        kontrol("reset_deger", deger, 32'd0);
        kontrol("reset_ana_istek", {31'b0, ana_istek}, 32'd0);
        kontrol("reset_ana_adres", ana_adres, 32'd0);
`ifdef ONBELLEK_SAYAC_EN
        kontrol("reset_isabet_sayisi", isabet_sayisi, 32'd0);
        kontrol("reset_iska_sayisi", iska_sayisi, 32'd0);
`endif
        rst = 1'b0;
        adim(2);

        // Cold miss with 2 wait cycles per beat
        adr_q.delete();
        v0 = vurus;
        iste(32'h100);
        yanit_bekle("soguk_iska_100", mem_kelime(32'h100), g);
        kontrol("soguk_vurus", 32'(vurus - v0), 32'd4);
        kontrol("soguk_adres_sayisi", 32'(adr_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            kontrol($sformatf("soguk_adres%0d", i), adr_q[i], 32'h100 + 32'(4 * i));
        end

        // Hits after the fill
        v0 = vurus;
        iste(32'h108);
        yanit_bekle("isabet_108", mem_kelime(32'h108), g);
        kontrol("isabet_gecikme", 32'(g), 32'd1);
        adim(3);
        kontrol("isabet_ana_istek_yok", 32'(vurus - v0), 32'd0);

        istek = 1'b1;
        ps    = 32'h104;
        adim();
        ps    = 32'h10C;
        adim();
        istek = 1'b0;
        yanit_bekle("ardisik_104", mem_kelime(32'h104), g);
        yanit_bekle("ardisik_10c", mem_kelime(32'h10C), g);

        // Conflict: 0x500 maps to the same line as 0x100
        mem_bekleme = 0;
        v0 = vurus;
        iste(32'h508);
        yanit_bekle("cakisma_508", mem_kelime(32'h508), g);
        kontrol("cakisma_508_vurus", 32'(vurus - v0), 32'd4);
        mem_bekleme = 2;
        v0 = vurus;
        iste(32'h100);
        yanit_bekle("cakisma_100_tekrar", mem_kelime(32'h100), g);
        kontrol("cakisma_100_vurus", 32'(vurus - v0), 32'd4);

        // Redirect: two newer requests arrive during the 0x200 refill
        v0 = vurus;
        iste(32'h200);
        vurus_bekle("yonlendirme_dolum_basladi", v0 + 1);
        iste(32'h300);
        adim(2);
        iste(32'h400);
        yanit_bekle("yonlendirme_400", mem_kelime(32'h400), g);
        adim(20);
        kontrol("yonlendirme_tek_yanit", 32'(got_q.size()), 32'd0);
        kontrol("yonlendirme_vurus", 32'(vurus - v0), 32'd8);
        v0 = vurus;
        iste(32'h20C);
        yanit_bekle("yonlendirme_200_gecerli", mem_kelime(32'h20C), g);
        kontrol("yonlendirme_200_gecikme", 32'(g), 32'd1);
        kontrol("yonlendirme_200_vurus", 32'(vurus - v0), 32'd0);

        // fence.i during the refill of 0x500
        v0 = vurus;
        iste(32'h504);
        vurus_bekle("fence_ilk_vurus", v0 + 1);
        temizle = 1'b1;
        adim();
        temizle = 1'b0;
        yanit_bekle("fence_504", mem_kelime(32'h504), g);
        kontrol("fence_504_vurus", 32'(vurus - v0), 32'd4);
        v0 = vurus;
        iste(32'h500);
        yanit_bekle("fence_500_tekrar", mem_kelime(32'h500), g);
        kontrol("fence_500_iska", 32'(vurus - v0), 32'd4);
        v0 = vurus;
        iste(32'h200);
        yanit_bekle("fence_200", mem_kelime(32'h200), g);
        kontrol("fence_200_iska", 32'(vurus - v0), 32'd4);
        v0 = vurus;
        iste(32'h100);
        yanit_bekle("fence_100", mem_kelime(32'h100), g);
        kontrol("fence_100_iska", 32'(vurus - v0), 32'd4);

        // Flush in the same cycle as a request to a valid line: treated as miss
        v0 = vurus;
        istek   = 1'b1;
        temizle = 1'b1;
        ps      = 32'h208;
        adim();
        istek   = 1'b0;
        temizle = 1'b0;
        yanit_bekle("temizle_istek_208", mem_kelime(32'h208), g);
        kontrol("temizle_istek_iska", 32'(vurus - v0), 32'd4);

        // Reset after the first beat of a refill
        v0 = vurus;
        iste(32'h600);
        vurus_bekle("reset_ilk_vurus", v0 + 1);
        rst = 1'b1;
        adim();
        kontrol("orta_reset_ana_istek", {31'b0, ana_istek}, 32'd0);
        kontrol("orta_reset_gecerli", {31'b0, gecerli}, 32'd0);
`ifdef ONBELLEK_SAYAC_EN
        kontrol("orta_reset_isabet", isabet_sayisi, 32'd0);
        kontrol("orta_reset_iska", iska_sayisi, 32'd0);
`endif
        rst = 1'b0;
        adim(5);
        kontrol("orta_reset_yanit_yok", 32'(got_q.size()), 32'd0);
        v0 = vurus;
        iste(32'h100);
        yanit_bekle("reset_sonrasi_100", mem_kelime(32'h100), g);
        kontrol("reset_sonrasi_iska", 32'(vurus - v0), 32'd4);

        adim(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
